// File: rtl/sn_pipe_counter_pkg.sv
// Sizing helpers and the Batcher odd-even merge comparator table used by the
// pipelined sorting-network parallel counter.
package sn_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned next_pow2(input int unsigned n);
        return 32'(64'd1 << clog2(n));
    endfunction

    function automatic int unsigned batcher_layers(input int unsigned k);
        return (k * (k + 1)) / 2;
    endfunction

    function automatic int unsigned num_stages(input int unsigned d, input int unsigned l);
        return (d + l - 1) / l;
    endfunction

    // Layers are ordered by merge size p = 2^m, then by stride k = p, p/2, ... 1.
    function automatic int unsigned layer_merge(input int unsigned layer);
        int unsigned m;
        m = 0;
        while (((m + 1) * (m + 2)) / 2 <= layer) m = m + 1;
        return m;
    endfunction

    function automatic int unsigned layer_stride(input int unsigned layer);
        int unsigned m;
        int unsigned t;
        m = layer_merge(layer);
        t = layer - (m * (m + 1)) / 2;
        return 32'd1 << (m - t);
    endfunction

    // True when lane is the low side of a compare-exchange (lane, lane + stride).
    function automatic bit is_lo(input int unsigned lanes, input int unsigned layer,
                                 input int unsigned lane);
        int unsigned p;
        int unsigned k;
        int unsigned off;
        p   = 32'd1 << layer_merge(layer);
        k   = layer_stride(layer);
        off = k % p;
        if (lane < off || lane + k >= lanes) return 1'b0;
        if (((lane - off) % (2 * k)) >= k) return 1'b0;
        return (lane / (2 * p)) == ((lane + k) / (2 * p));
    endfunction

    // Comparator table lookup: partner lane of `lane` in `layer`, or -1 if it passes through.
    function automatic int cmp_partner(input int unsigned lanes, input int unsigned layer,
                                       input int unsigned lane);
        int unsigned k;
        k = layer_stride(layer);
        if (is_lo(lanes, layer, lane)) return int'(lane + k);
        if (lane >= k && is_lo(lanes, layer, lane - k)) return int'(lane - k);
        return -1;
    endfunction

endpackage

// File: rtl/sn_pipe_counter_if.sv
// Beat-in / result-out stream bundle of the sorting-network counter.
interface sn_pipe_counter_if #(
    parameter int unsigned N  = 15,
    parameter int unsigned SW = 16
);
    localparam int unsigned CW = sn_pkg::clog2(N + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_bits;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_therm;
    logic [CW-1:0] out_count;
    logic [SW-1:0] out_sum;
    logic          out_sat;
    logic          out_last;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_therm, out_count, out_sum, out_sat, out_last
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_therm, out_count, out_sum, out_sat, out_last
    );
endinterface

// File: rtl/sn_pipe_counter_cmp_layer.sv
// One comparator layer of the Batcher network: min = a & b to the low lane,
// max = a | b to the high lane, untouched lanes pass straight through.
module sn_cmp_layer
    import sn_pkg::*;
#(
    parameter int unsigned P     = 16,
    parameter int unsigned LAYER = 0
) (
    input  logic [P-1:0] lanes_i,
    output logic [P-1:0] lanes_o
);

    for (genvar a = 0; a < int'(P); a++) begin : g_lane
        localparam int PARTNER = cmp_partner(P, LAYER, a);
        if (PARTNER < 0) begin : g_pass
            assign lanes_o[a] = lanes_i[a];
        end else if (PARTNER > a) begin : g_min
            assign lanes_o[a] = lanes_i[a] & lanes_i[PARTNER];
        end else begin : g_max
            assign lanes_o[a] = lanes_i[a] | lanes_i[PARTNER];
        end
    end

endmodule

// File: rtl/sn_pipe_counter.sv
// Pipelined sorting-network popcount with valid/ready flow control and a
// per-frame saturating running sum.
module sn_pipe_counter
    import sn_pkg::*;
#(
    parameter int unsigned N  = 15,
    parameter int unsigned L  = 2,
    parameter int unsigned SW = 16
) (
    input logic            clk,
    input logic            rst_n,
    sn_pipe_counter_if.slave bus
);

    localparam int unsigned P  = next_pow2(N);
    localparam int unsigned K  = clog2(P);
    localparam int unsigned D  = batcher_layers(K);
    localparam int unsigned S  = num_stages(D, L);
    localparam int unsigned CW = clog2(N + 1);

    logic         adv_c;
    logic [P-1:0] in_lanes_c;
    logic [P-1:0] layer_in  [D];
    logic [P-1:0] layer_out [D];
    logic [P-1:0] stage_out [S];

    logic [P-1:0] st_lanes_q [S];
    logic [P-1:0] st_lanes_d [S];
    logic [S-1:0] st_valid_q, st_valid_d;
    logic [S-1:0] st_last_q,  st_last_d;

    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_therm_q, out_therm_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic [SW-1:0] out_sum_q,   out_sum_d;
    logic          out_sat_q,   out_sat_d;
    logic          out_last_q,  out_last_d;
    logic          frame_start_q, frame_start_d;

    logic [P-1:0]  final_lanes;
    logic [N-1:0]  therm_c;
    logic [CW-1:0] count_c;
    logic          xfer_c;
    logic          fs_c;
    logic [SW-1:0] base_c;
    logic          sat_base_c;
    logic [SW:0]   sum_wide_c;

    // Whole pipeline moves in lockstep; no skid buffer.
    assign adv_c        = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv_c;

    // Pad lanes are constant zero and always sort to the bottom.
    always_comb begin
        in_lanes_c        = '0;
        in_lanes_c[N-1:0] = bus.in_bits;
    end

    for (genvar i = 0; i < int'(D); i++) begin : g_layer
        if (i == 0) begin : g_src_in
            assign layer_in[i] = in_lanes_c;
        end else if ((i % int'(L)) == 0) begin : g_src_reg
            assign layer_in[i] = st_lanes_q[i / int'(L) - 1];
        end else begin : g_src_comb
            assign layer_in[i] = layer_out[i - 1];
        end
        sn_cmp_layer #(.P(P), .LAYER(i)) u_layer (
            .lanes_i (layer_in[i]),
            .lanes_o (layer_out[i])
        );
    end

    for (genvar j = 0; j < int'(S); j++) begin : g_tap
        localparam int unsigned LAST_LAYER = ((j + 1) * L < D) ? (j + 1) * L - 1 : D - 1;
        assign stage_out[j] = layer_out[LAST_LAYER];
    end

    always_comb begin
        st_lanes_d = st_lanes_q;
        st_valid_d = st_valid_q;
        st_last_d  = st_last_q;
        if (adv_c) begin
            st_lanes_d[0] = stage_out[0];
            st_valid_d[0] = bus.in_valid;
            st_last_d[0]  = bus.in_last;
            for (int j = 1; j < int'(S); j++) begin
                st_lanes_d[j] = stage_out[j];
                st_valid_d[j] = st_valid_q[j - 1];
                st_last_d[j]  = st_last_q[j - 1];
            end
        end
    end

    assign final_lanes = st_lanes_q[S - 1];

    if (P > N) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^final_lanes[P - N - 1:0];
    end

    // Reverse the top N lanes so therm bit i means count > i.
    always_comb begin
        therm_c = '0;
        count_c = '0;
        for (int i = 0; i < int'(N); i++) begin
            therm_c[i] = final_lanes[int'(P) - 1 - i];
        end
        for (int i = 0; i < int'(N); i++) begin
            if (therm_c[i]) count_c = CW'(i + 1);
        end
    end

    // A beat loading alongside a last-beat transfer starts a fresh frame at once.
    always_comb begin
        xfer_c     = out_valid_q && bus.out_ready;
        fs_c       = xfer_c ? out_last_q : frame_start_q;
        base_c     = fs_c ? '0 : out_sum_q;
        sat_base_c = fs_c ? 1'b0 : out_sat_q;
        sum_wide_c = {1'b0, base_c} + (SW + 1)'(count_c);

        out_valid_d   = out_valid_q;
        out_therm_d   = out_therm_q;
        out_count_d   = out_count_q;
        out_sum_d     = out_sum_q;
        out_sat_d     = out_sat_q;
        out_last_d    = out_last_q;
        frame_start_d = fs_c;

        if (adv_c) begin
            out_valid_d = st_valid_q[S - 1];
            if (st_valid_q[S - 1]) begin
                out_therm_d = therm_c;
                out_count_d = count_c;
                out_last_d  = st_last_q[S - 1];
                if (sum_wide_c[SW]) begin
                    out_sum_d = '1;
                    out_sat_d = 1'b1;
                end else begin
                    out_sum_d = sum_wide_c[SW - 1:0];
                    out_sat_d = sat_base_c;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < int'(S); j++) st_lanes_q[j] <= '0;
            st_valid_q    <= '0;
            st_last_q     <= '0;
            out_valid_q   <= 1'b0;
            out_therm_q   <= '0;
            out_count_q   <= '0;
            out_sum_q     <= '0;
            out_sat_q     <= 1'b0;
            out_last_q    <= 1'b0;
            frame_start_q <= 1'b1;
        end else begin
            st_lanes_q    <= st_lanes_d;
            st_valid_q    <= st_valid_d;
            st_last_q     <= st_last_d;
            out_valid_q   <= out_valid_d;
            out_therm_q   <= out_therm_d;
            out_count_q   <= out_count_d;
            out_sum_q     <= out_sum_d;
            out_sat_q     <= out_sat_d;
            out_last_q    <= out_last_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_therm = out_therm_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_last  = out_last_q;

endmodule
